// File: rtl/reservoir_pkg.sv
// Shared types, Q-format defaults and the saturation helper for the LIF reservoir.
package reservoir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StUpdate,
    StCommit
  } state_e;

  localparam int unsigned AccW    = 32;  // synaptic accumulator width
  localparam int unsigned WideW   = 64;  // headroom for leak product and sum before clamping
  localparam int unsigned RefracW = 4;   // refractory counter width (0..15)

  localparam int unsigned DefFrac   = 12;    // Q4.12 at DW=16
  localparam int          DefThresh = 2048;  // 0.5
  localparam int          DefLeak   = 3686;  // ~0.9

  // Clamp a wide signed value to the range of a dw-bit signed number.
  function automatic logic signed [WideW-1:0] saturate(input logic signed [WideW-1:0] x,
                                                       input int unsigned dw);
    logic signed [WideW-1:0] hi;
    logic signed [WideW-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational membrane update for one neuron: leak, integrate, clamp, fire, refractory.
module lif_update_unit
  import reservoir_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned FRAC   = DefFrac,
  parameter int          THRESH = DefThresh,
  parameter int          LEAK   = DefLeak,
  parameter int unsigned REFRAC = 2
) (
  input  logic signed [DW-1:0]      v_i,
  input  logic signed [AccW-1:0]    acc_i,
  input  logic        [RefracW-1:0] refrac_i,
  output logic signed [DW-1:0]      v_o,
  output logic        [RefracW-1:0] refrac_o,
  output logic                      spike_o
);

  localparam logic signed [WideW-1:0] LeakW   = WideW'(LEAK);
  localparam logic signed [WideW-1:0] ThreshW = WideW'(THRESH);

  logic signed [WideW-1:0] leaked;
  logic signed [WideW-1:0] summed;
  logic signed [WideW-1:0] clamped;

  // Candidate potential and the fire / hold decision.
  always_comb begin
    leaked   = (WideW'(v_i) * LeakW) >>> FRAC;
    summed   = leaked + WideW'(acc_i);
    clamped  = saturate(summed, DW);
    v_o      = v_i;
    refrac_o = refrac_i;
    spike_o  = 1'b0;
    if (refrac_i != '0) begin
      // Refractory: potential frozen, input discarded.
      refrac_o = refrac_i - RefracW'(1);
    end else if (clamped > ThreshW) begin
      spike_o  = 1'b1;
      v_o      = '0;
      refrac_o = RefracW'(REFRAC);
    end else begin
      v_o = clamped[DW-1:0];
    end
  end

endmodule

// File: rtl/lif_reservoir_tm.sv
// Time-multiplexed LIF reservoir: one synapse per cycle, one neuron update per N+1 cycles.
module lif_reservoir_tm
  import reservoir_pkg::*;
#(
  parameter int unsigned N      = 64,
  parameter int unsigned DW     = 16,
  parameter int unsigned FRAC   = DefFrac,
  parameter int          THRESH = DefThresh,
  parameter int          LEAK   = DefLeak,
  parameter int unsigned REFRAC = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step_valid,
  output logic                       step_ready,
  input  logic signed [DW-1:0]       input_signal,
  input  logic                       wr_en,
  input  logic [$clog2(N)-1:0]       wr_row,
  input  logic [$clog2(N+1)-1:0]     wr_col,
  input  logic signed [DW-1:0]       wr_data,
  output logic [N-1:0]               spikes_out,
  output logic                       spikes_valid
);

  localparam int unsigned RW    = $clog2(N);
  localparam int unsigned CW    = $clog2(N + 1);
  localparam int unsigned Words = N * (N + 1);
  localparam int unsigned AW    = $clog2(Words);
  localparam int unsigned PW    = 2 * DW;

  localparam logic [RW-1:0] RowLast = RW'(N - 1);
  localparam logic [CW-1:0] ColLast = CW'(N - 1);
  localparam logic [CW-1:0] ColIn   = CW'(N);  // column index of the external-input weight

  state_e                    state_q, state_d;
  logic [RW-1:0]             row_q, row_d;
  logic [CW-1:0]             col_q, col_d;
  logic signed [DW-1:0]      inp_q, inp_d;
  logic signed [AccW-1:0]    acc_q, acc_d;
  logic signed [DW-1:0]      v_q [N];
  logic signed [DW-1:0]      v_d [N];
  logic [RefracW-1:0]        refrac_q [N];
  logic [RefracW-1:0]        refrac_d [N];
  logic [N-1:0]              shadow_q, shadow_d;
  logic [N-1:0]              spikes_q, spikes_d;

  logic signed [DW-1:0]      mem_q [Words];
  logic signed [DW-1:0]      rdata_q;
  logic [AW-1:0]             raddr;
  logic [AW-1:0]             waddr;
  logic                      wr_fire;

  logic signed [PW-1:0]      win_prod;
  logic signed [AccW-1:0]    acc_init;
  logic signed [AccW-1:0]    w_term;
  logic signed [AccW-1:0]    acc_eff;
  logic                      prev_spk;

  logic signed [DW-1:0]      upd_v;
  logic [RefracW-1:0]        upd_refrac;
  logic                      upd_spike;

  // Row i occupies words i*(N+1) .. i*(N+1)+N; the last one is W_in[i].
  function automatic logic [AW-1:0] word_addr(input logic [RW-1:0] row,
                                              input logic [CW-1:0] col);
    return AW'(row) * AW'(N + 1) + AW'(col);
  endfunction

  // RAM addressing: reads are issued one cycle ahead of their use.
  always_comb begin
    wr_fire = wr_en && (state_q == StIdle) && (wr_col <= ColIn);
    waddr   = word_addr(wr_row, wr_col);
    raddr   = '0;
    case (state_q)
      StIdle:   raddr = word_addr('0, ColIn);
      StAccum:  raddr = word_addr(row_q, col_q);
      StUpdate: raddr = (row_q == RowLast) ? '0 : word_addr(row_q + RW'(1), ColIn);
      default:  raddr = '0;
    endcase
  end

  // Weight RAM, write-first so a write in the handshake cycle reaches the first read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[waddr] <= wr_data;
    end
    rdata_q <= (wr_fire && (waddr == raddr)) ? wr_data : mem_q[raddr];
  end

  // Synapse datapath; rdata_q lags the column counter by one, so column c adds W[i][c-1].
  always_comb begin
    prev_spk = spikes_q[RW'(col_q - CW'(1))];
    w_term   = prev_spk ? AccW'(rdata_q) : '0;
    acc_eff  = acc_q + w_term;
    win_prod = PW'(rdata_q) * PW'(inp_q);
    acc_init = AccW'(win_prod >>> FRAC);
  end

  lif_update_unit #(
    .DW     (DW),
    .FRAC   (FRAC),
    .THRESH (THRESH),
    .LEAK   (LEAK),
    .REFRAC (REFRAC)
  ) u_update (
    .v_i      (v_q[row_q]),
    .acc_i    (acc_eff),
    .refrac_i (refrac_q[row_q]),
    .v_o      (upd_v),
    .refrac_o (upd_refrac),
    .spike_o  (upd_spike)
  );

  // Step sequencer: ACCUM x N then UPDATE per neuron, then COMMIT.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    inp_d    = inp_q;
    acc_d    = acc_q;
    v_d      = v_q;
    refrac_d = refrac_q;
    shadow_d = shadow_q;
    spikes_d = spikes_q;
    case (state_q)
      StIdle: begin
        if (step_valid) begin
          state_d = StAccum;
          row_d   = '0;
          col_d   = '0;
          inp_d   = input_signal;
        end
      end
      StAccum: begin
        // Column 0 sees W_in[i] on the read port; later columns see the previous synapse.
        acc_d = (col_q == '0) ? acc_init : acc_eff;
        col_d = col_q + CW'(1);
        if (col_q == ColLast) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        v_d[row_q]      = upd_v;
        refrac_d[row_q] = upd_refrac;
        shadow_d[row_q] = upd_spike;
        col_d           = '0;
        if (row_q == RowLast) begin
          // Publish the full shadow so spikes_out is valid throughout COMMIT.
          state_d  = StCommit;
          spikes_d = shadow_d;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = StAccum;
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; weight RAM is deliberately left untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      inp_q    <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      spikes_q <= '0;
      for (int k = 0; k < N; k++) begin
        v_q[k]      <= '0;
        refrac_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      inp_q    <= inp_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      spikes_q <= spikes_d;
      v_q      <= v_d;
      refrac_q <= refrac_d;
    end
  end

  assign step_ready   = (state_q == StIdle);
  assign spikes_valid = (state_q == StCommit);
  assign spikes_out   = spikes_q;

endmodule

// File: tb/tb_lif_reservoir_tm.sv
// Directed bench for lif_reservoir_tm with N=4 (second instance uses THRESH=32767).
module tb_lif_reservoir_tm;

  localparam int N   = 4;
  localparam int LAT = N * (N + 1) + 1;

  logic               clk;
  logic               reset;
  logic               step_valid;
  logic signed [15:0] input_signal;
  logic               wr_en;
  logic [1:0]         wr_row;
  logic [2:0]         wr_col;
  logic signed [15:0] wr_data;
  logic               step_ready_a, step_ready_b;
  logic [N-1:0]       spikes_out_a, spikes_out_b;
  logic               spikes_valid_a, spikes_valid_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] sb[$];

  lif_reservoir_tm #(.N(N)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .step_valid   (step_valid),
    .step_ready   (step_ready_a),
    .input_signal (input_signal),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .spikes_out   (spikes_out_a),
    .spikes_valid (spikes_valid_a)
  );

  lif_reservoir_tm #(.N(N), .THRESH(32767)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .step_valid   (step_valid),
    .step_ready   (step_ready_b),
    .input_signal (input_signal),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .spikes_out   (spikes_out_b),
    .spikes_valid (spikes_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic write_w(input int r, input int c, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_row  = 2'(r);
    wr_col  = 3'(c);
    wr_data = 16'(d);
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic clear_w();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c <= N; c++) begin
        write_w(r, c, 0);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One step: push the expectation, handshake, wait (bounded) for spikes_valid, pop and compare.
  // hold keeps step_valid and a W_in[0]=0 write asserted while busy; hs_wr writes W_in[0]=4096
  // in the handshake cycle itself.
  task automatic run_step(input logic [N-1:0] exp_sp, input int inp, input bit hold,
                          input bit hs_wr, input string tag);
    int cnt;
    logic [N-1:0] e;
    sb.push_back(exp_sp);
    @(negedge clk);
    input_signal = 16'(inp);
    step_valid   = 1'b1;
    if (hs_wr) begin
      wr_en = 1'b1; wr_row = 2'd0; wr_col = 3'(N); wr_data = 16'sd4096;
    end
    check({tag, "_ready_pre"}, step_ready_a, 1);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (hold) begin
      wr_en = 1'b1; wr_row = 2'd0; wr_col = 3'(N); wr_data = 16'sd0;
    end else begin
      step_valid = 1'b0;
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!spikes_valid_a && cnt < 200);
    step_valid = 1'b0;
    wr_en      = 1'b0;
    check({tag, "_latency"}, cnt, LAT);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_spikes"}, spikes_out_a, e);
    end
    @(negedge clk);
    check({tag, "_ready_post"}, step_ready_a, 1);
    check({tag, "_valid_pulse"}, spikes_valid_a, 0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; step_valid = 1'b0; input_signal = '0;
    wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", step_ready_a, 1);
    check("rst_spikes", spikes_out_a, 0);
    check("rst_valid", spikes_valid_a, 0);

    // All neurons driven to 3000 > 2048: fire, two refractory steps, fire again.
    clear_w();
    for (int i = 0; i < N; i++) write_w(i, N, 4096);
    run_step(4'b1111, 3000, 0, 0, "all1");
    for (int i = 0; i < N; i++) check("all1_v_zero", dut_a.v_q[i], 0);
    run_step(4'b0000, 3000, 0, 0, "all2");
    run_step(4'b0000, 3000, 0, 0, "all3");
    run_step(4'b1111, 3000, 0, 0, "all4");

    // Leaky integration: 1000, 899+1000=1899, 1708+1000=2708 > 2048 fires.
    do_reset();
    clear_w();
    write_w(0, N, 4096);
    run_step(4'b0000, 1000, 0, 0, "leak1");
    check("leak1_v", dut_a.v_q[0], 1000);
    run_step(4'b0000, 1000, 0, 0, "leak2");
    check("leak2_v", dut_a.v_q[0], 1899);
    run_step(4'b0001, 1000, 0, 0, "leak3");
    check("leak3_v", dut_a.v_q[0], 0);

    // Recurrence: neuron 1 fires one step after neuron 0.
    do_reset();
    clear_w();
    write_w(0, N, 4096);
    write_w(1, 0, 2100);
    run_step(4'b0001, 3000, 0, 0, "rec1");
    run_step(4'b0010, 3000, 0, 0, "rec2");
    run_step(4'b0000, 3000, 0, 0, "rec3");

    // Saturation on the high-threshold instance.
    do_reset();
    clear_w();
    write_w(0, N, 32767);
    run_step(4'b0001, 32767, 0, 0, "satp1");
    check("satp1_v_b", dut_b.v_q[0], 32767);
    check("satp1_spk_b", spikes_out_b, 0);
    run_step(4'b0000, 32767, 0, 0, "satp2");
    check("satp2_v_b", dut_b.v_q[0], 32767);
    check("satp2_spk_b", spikes_out_b, 0);
    do_reset();
    run_step(4'b0000, -32767, 0, 0, "satn");
    check("satn_v_b", dut_b.v_q[0], -32768);
    check("satn_v_a", dut_a.v_q[0], -32768);
    check("satn_spk_b", spikes_out_b, 0);

    // Write in the handshake cycle is seen by the same step.
    do_reset();
    clear_w();
    run_step(4'b0001, 3000, 0, 1, "hswr");

    // Held step_valid/wr_en while busy are ignored; no queued step follows.
    do_reset();
    run_step(4'b0001, 3000, 1, 0, "hold");
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (spikes_valid_a) pulses++;
    end
    check("hold_no_queue", pulses, 0);

    // Reset mid-ACCUM aborts the step; weights survive.
    @(negedge clk);
    input_signal = 16'sd3000;
    step_valid   = 1'b1;
    @(posedge clk);
    #1 step_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready", step_ready_a, 1);
    check("abort_spikes", spikes_out_a, 0);
    check("abort_valid", spikes_valid_a, 0);
    run_step(4'b0001, 3000, 0, 0, "retain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
